// File: rtl/multiplier_control_unit.sv
// Sequencing FSM for the signed add-shift multiplier.
// Define MULT_MERGE_ADD_SHIFT_EN to merge ADD and SHIFT into one ITER state.
module multiplier_control_unit #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_A,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_BITS - 1);

`ifdef MULT_MERGE_ADD_SHIFT_EN
  typedef enum logic [2:0] {
    IDLE, CLR, ITER, HALT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CLR, ADD, SHIFT, HALT
  } state_t;
`endif

  state_t        state;
  state_t        state_nx;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nx;
  logic          last;

  // The final iteration subtracts to correct for the multiplier sign bit.
  assign last = (k == K_LAST);

  // State and iteration counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    Clr_Ld   = 1'b0;
    Clr_A    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        if (Run) begin
          state_nx = CLR;
          k_nx     = '0;
        end else begin
          Clr_Ld = ClearA_LoadB;
        end
      end
      CLR: begin
        Clr_A = 1'b1;
        Busy  = 1'b1;
`ifdef MULT_MERGE_ADD_SHIFT_EN
        state_nx = ITER;
`else
        state_nx = ADD;
`endif
      end
`ifdef MULT_MERGE_ADD_SHIFT_EN
      ITER: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        Add   = M & ~last;
        Sub   = M & last;
        if (last) begin
          state_nx = HALT;
        end else begin
          k_nx = k + KW'(1);
        end
      end
`else
      ADD: begin
        Busy     = 1'b1;
        Add      = M & ~last;
        Sub      = M & last;
        state_nx = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (last) begin
          state_nx = HALT;
        end else begin
          k_nx     = k + KW'(1);
          state_nx = ADD;
        end
      end
`endif
      HALT: begin
        Done = 1'b1;
        if (!Run) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Directed vector bench for multiplier_control_unit.
// Honours MULT_MERGE_ADD_SHIFT_EN for the merged ITER timing.
module tb_multiplier_control_unit;

  logic Clk = 1'b0;
  logic Reset_n;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld;
  logic Clr_A;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;

  multiplier_control_unit #(.N_BITS(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Clr_A        (Clr_A),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  // Expected bits: {Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done}
  localparam logic [6:0] E_NONE  = 7'b0000000;
  localparam logic [6:0] E_CLRLD = 7'b1000000;
  localparam logic [6:0] E_CLR   = 7'b0100010;
  localparam logic [6:0] E_ADD   = 7'b0010000;
  localparam logic [6:0] E_SUB   = 7'b0001000;
  localparam logic [6:0] E_BUSY  = 7'b0000010;
  localparam logic [6:0] E_SHIFT = 7'b0000110;
  localparam logic [6:0] E_DONE  = 7'b0000001;

  typedef struct {
    bit         rst_n;
    bit         run;
    bit         cl;
    bit         m;
    logic [6:0] exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_bad = 0;

  function automatic void push_vec(bit r, bit ru, bit c, bit mm,
                                   logic [6:0] e, string t);
    vec_t v;
    v.rst_n = r;
    v.run   = ru;
    v.cl    = c;
    v.m     = mm;
    v.exp   = e;
    v.tag   = t;
    vecs.push_back(v);
  endfunction

  // CLR then the iterations; rst_at marks the iteration whose last
  // cycle carries Reset_n=0 (8 = no reset).
  task automatic push_run(input logic [7:0] ms, input logic [7:0] am,
                          input logic [7:0] sm, input bit ru, input bit c,
                          input int rst_at, input string t);
    push_vec(1'b1, ru, c, 1'b0, E_CLR, {t, "_clr"});
    for (int i = 0; i < 8; i++) begin
      logic [6:0] e;
      e = (am[i] ? E_ADD : E_NONE) | (sm[i] ? E_SUB : E_NONE);
`ifdef MULT_MERGE_ADD_SHIFT_EN
      push_vec(i != rst_at, ru, c, ms[i], E_SHIFT | e,
               {t, "_iter", $sformatf("%0d", i)});
`else
      push_vec(1'b1, ru, c, ms[i], E_BUSY | e,
               {t, "_add", $sformatf("%0d", i)});
      push_vec(i != rst_at, ru, c, ~ms[i], E_SHIFT,
               {t, "_shift", $sformatf("%0d", i)});
`endif
      if (i == rst_at) break;
    end
  endtask

  initial begin
    logic [6:0] got;
    int         wait_n;

    // Iterations 0,2,3,6 add; iteration 7 subtracts.
    push_vec(1'b0, 1'b1, 1'b0, 1'b0, E_NONE, "reset_hold");
    push_vec(1'b1, 1'b1, 1'b0, 1'b0, E_NONE, "reset_release");
    push_run(8'b11001101, 8'b01001101, 8'h80, 1'b1, 1'b0, 8, "run1");
    for (int i = 0; i < 22; i++)
      push_vec(1'b1, 1'b1, 1'b0, 1'b1, E_DONE, "halt_hold");
    push_vec(1'b1, 1'b0, 1'b0, 1'b1, E_DONE, "halt_drop");
    push_vec(1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "idle_back");

    // Load priority, Run dropped mid-run, ClearA_LoadB ignored when busy.
    push_vec(1'b1, 1'b0, 1'b1, 1'b0, E_CLRLD, "idle_clrld");
    push_vec(1'b1, 1'b1, 1'b1, 1'b0, E_NONE, "idle_prio");
    push_run(8'hFF, 8'h7F, 8'h80, 1'b0, 1'b1, 8, "run2");
    push_vec(1'b1, 1'b0, 1'b1, 1'b0, E_DONE, "halt_once");
    push_vec(1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "idle2");

    // Reset in iteration 4.
    push_vec(1'b1, 1'b1, 1'b0, 1'b0, E_NONE, "idle3");
    push_run(8'hFF, 8'h7F, 8'h80, 1'b1, 1'b0, 4, "run3");
    push_vec(1'b1, 1'b0, 1'b0, 1'b1, E_NONE, "post_rst");
    push_vec(1'b1, 1'b0, 1'b0, 1'b1, E_NONE, "post_rst2");

    // Full run after reset; M=0 on the last iteration.
    push_vec(1'b1, 1'b1, 1'b0, 1'b0, E_NONE, "idle4");
    push_run(8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 8, "run4");
    push_vec(1'b1, 1'b0, 1'b0, 1'b0, E_DONE, "halt4");
    push_vec(1'b1, 1'b0, 1'b0, 1'b0, E_NONE, "idle5");

    Reset_n      = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b0;
    M            = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    got = {Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done};
    n_applied++;
    if (got !== E_NONE) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", got, E_NONE);
    end

    foreach (vecs[i]) begin
      Reset_n      = vecs[i].rst_n;
      Run          = vecs[i].run;
      ClearA_LoadB = vecs[i].cl;
      M            = vecs[i].m;
      #2;
      got = {Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done};
      n_applied++;
      if (got !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL %s (vec %0d): got %b want %b",
                 vecs[i].tag, i, got, vecs[i].exp);
      end
      @(posedge Clk);
      #1;
    end

    Reset_n      = 1'b1;
    Run          = 1'b1;
    ClearA_LoadB = 1'b0;
    M            = 1'b1;
    wait_n       = 0;
    while (!Done && wait_n < 40) begin
      @(posedge Clk);
      #1;
      wait_n++;
    end
    n_applied++;
    if (!Done) begin
      n_bad++;
      $display("FAIL done_wait: Done not seen within %0d cycles",
               wait_n);
    end
    Run = 1'b0;
    @(posedge Clk);
    #1;
    got = {Clr_Ld, Clr_A, Add, Sub, Shift, Busy, Done};
    n_applied++;
    if (got !== E_NONE) begin
      n_bad++;
      $display("FAIL done_wait_idle: got %b want %b", got, E_NONE);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_applied, n_bad);
    $finish;
  end

endmodule
